// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Time-shares one external combinational 64-bit ALU (add/sub/and/xor) between
// two requesters: req0 (execute-stage op) and req1 (address / stack-pointer
// calculation). A three-state FSM (IDLE -> EXEC -> RESP) accepts one op,
// drives the shared ALU from registered operands for one cycle, captures the
// result, and presents it on a valid/ready response port. The block also owns
// the Y86 condition codes (ZF/SF/OF), which only req0 ops may update.
//
// Build option:
//   ALU_ARB_FIXED_PRIO_EN  defined   -> req0 always wins when valid.
//                          undefined -> round-robin on ties via last_grant.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req0_valid/ready         requester 0 handshake (ready is combinational)
//   req0_a/b/fn/set_cc       requester 0 operands, function, CC-update flag
//   req1_valid/ready         requester 1 handshake (ready is combinational)
//   req1_a/b/fn              requester 1 operands and function
//   alu_a/b/fn               registered operands to the shared ALU
//   alu_result/overflow      combinational result and signed overflow back
//   rsp_valid/ready          response handshake
//   rsp_id, rsp_result       owner of the response and its registered result
//   cc_zf, cc_sf, cc_of      condition codes
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int W    = 64,
  parameter int FN_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [W-1:0]    req0_a,
  input  logic [W-1:0]    req0_b,
  input  logic [FN_W-1:0] req0_fn,
  input  logic            req0_set_cc,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [W-1:0]    req1_a,
  input  logic [W-1:0]    req1_b,
  input  logic [FN_W-1:0] req1_fn,
  output logic [W-1:0]    alu_a,
  output logic [W-1:0]    alu_b,
  output logic [FN_W-1:0] alu_fn,
  input  logic [W-1:0]    alu_result,
  input  logic            alu_overflow,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [W-1:0]    rsp_result,
  output logic            cc_zf,
  output logic            cc_sf,
  output logic            cc_of
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [FN_W-1:0] FN_ADD = FN_W'(2'd0);
  localparam logic [FN_W-1:0] FN_SUB = FN_W'(2'd1);

  logic [1:0]      state_q,      state_d;
  logic [W-1:0]    alu_a_q,      alu_a_d;
  logic [W-1:0]    alu_b_q,      alu_b_d;
  logic [FN_W-1:0] alu_fn_q,     alu_fn_d;
  logic            op_id_q,      op_id_d;
  logic            op_set_cc_q,  op_set_cc_d;
  logic            rsp_valid_q,  rsp_valid_d;
  logic            rsp_id_q,     rsp_id_d;
  logic [W-1:0]    rsp_result_q, rsp_result_d;
  logic            cc_zf_q,      cc_zf_d;
  logic            cc_sf_q,      cc_sf_d;
  logic            cc_of_q,      cc_of_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic            last_grant_q, last_grant_d;
`endif

  logic            grant_vld_s;
  logic            grant_id_s;
  logic [W-1:0]    sel_a_s;
  logic [W-1:0]    sel_b_s;
  logic [FN_W-1:0] sel_fn_s;
  logic            sel_set_cc_s;

  // Arbitration: only in IDLE and never during the reset cycle.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_id_s  = 1'b0;
    if ((state_q == ST_IDLE) && !rst) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      if (req0_valid) begin
        grant_vld_s = 1'b1;
        grant_id_s  = 1'b0;
      end else if (req1_valid) begin
        grant_vld_s = 1'b1;
        grant_id_s  = 1'b1;
      end else begin
        grant_vld_s = 1'b0;
      end
`else
      if (req0_valid && req1_valid) begin
        // Tie: hand the ALU to whoever did not win last time.
        grant_vld_s = 1'b1;
        grant_id_s  = ~last_grant_q;
      end else if (req0_valid) begin
        grant_vld_s = 1'b1;
        grant_id_s  = 1'b0;
      end else if (req1_valid) begin
        grant_vld_s = 1'b1;
        grant_id_s  = 1'b1;
      end else begin
        grant_vld_s = 1'b0;
      end
`endif
    end else begin
      grant_vld_s = 1'b0;
    end
  end

  // Operand mux for the granted requester; req1 can never touch the CCs.
  always_comb begin
    sel_a_s      = req0_a;
    sel_b_s      = req0_b;
    sel_fn_s     = req0_fn;
    sel_set_cc_s = req0_set_cc;
    if (grant_id_s) begin
      sel_a_s      = req1_a;
      sel_b_s      = req1_b;
      sel_fn_s     = req1_fn;
      sel_set_cc_s = 1'b0;
    end else begin
      sel_set_cc_s = req0_set_cc;
    end
  end

  assign req0_ready = grant_vld_s & ~grant_id_s;
  assign req1_ready = grant_vld_s &  grant_id_s;

  // FSM next-state, operand capture, result capture and CC update.
  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_fn_d     = alu_fn_q;
    op_id_d      = op_id_q;
    op_set_cc_d  = op_set_cc_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    cc_zf_d      = cc_zf_q;
    cc_sf_d      = cc_sf_q;
    cc_of_d      = cc_of_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_vld_s) begin
          alu_a_d     = sel_a_s;
          alu_b_d     = sel_b_s;
          alu_fn_d    = sel_fn_s;
          op_id_d     = grant_id_s;
          op_set_cc_d = sel_set_cc_s;
`ifndef ALU_ARB_FIXED_PRIO_EN
          last_grant_d = grant_id_s;
`endif
          state_d     = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        rsp_result_d = alu_result;
        rsp_id_d     = op_id_q;
        rsp_valid_d  = 1'b1;
        state_d      = ST_RESP;
        if (op_set_cc_q) begin
          cc_zf_d = (alu_result == {W{1'b0}});
          cc_sf_d = alu_result[W-1];
          // Overflow is only meaningful for the arithmetic functions.
          cc_of_d = ((alu_fn_q == FN_ADD) || (alu_fn_q == FN_SUB)) ? alu_overflow : 1'b0;
        end else begin
          cc_zf_d = cc_zf_q;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      alu_a_q      <= {W{1'b0}};
      alu_b_q      <= {W{1'b0}};
      alu_fn_q     <= {FN_W{1'b0}};
      op_id_q      <= 1'b0;
      op_set_cc_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= {W{1'b0}};
      cc_zf_q      <= 1'b1;
      cc_sf_q      <= 1'b0;
      cc_of_q      <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_fn_q     <= alu_fn_d;
      op_id_q      <= op_id_d;
      op_set_cc_q  <= op_set_cc_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      cc_zf_q      <= cc_zf_d;
      cc_sf_q      <= cc_sf_d;
      cc_of_q      <= cc_of_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_fn     = alu_fn_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign cc_zf      = cc_zf_q;
  assign cc_sf      = cc_sf_q;
  assign cc_of      = cc_of_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for alu_share_arbiter: drives both requesters, stands in for the
// shared ALU, and compares the DUT every cycle against a transaction-level
// model (one pending op, its accept cycle, and the CC/response it must yield).
// Directed ops pin the model with hand-computed results.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;
  localparam int W    = 64;
  localparam int FN_W = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            req0_valid, req0_ready, req0_set_cc;
  logic [W-1:0]    req0_a, req0_b;
  logic [FN_W-1:0] req0_fn;
  logic            req1_valid, req1_ready;
  logic [W-1:0]    req1_a, req1_b;
  logic [FN_W-1:0] req1_fn;
  logic [W-1:0]    alu_a, alu_b, alu_result;
  logic [FN_W-1:0] alu_fn;
  logic            alu_overflow;
  logic            rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0]    rsp_result;
  logic            cc_zf, cc_sf, cc_of;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.W(W), .FN_W(FN_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_fn(req0_fn), .req0_set_cc(req0_set_cc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_fn(req1_fn),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  // Shared ALU stand-in: overflow from a 65-bit sign-extended sum.
  logic [W:0] wide;
  always_comb begin
    wide         = '0;
    alu_result   = '0;
    alu_overflow = 1'b0;
    case (alu_fn)
      2'd0: begin
        wide = {alu_a[W-1], alu_a} + {alu_b[W-1], alu_b};
        alu_result = wide[W-1:0];
        alu_overflow = wide[W] ^ wide[W-1];
      end
      2'd1: begin
        wide = {alu_a[W-1], alu_a} - {alu_b[W-1], alu_b};
        alu_result = wide[W-1:0];
        alu_overflow = wide[W] ^ wide[W-1];
      end
      2'd2: alu_result = alu_a & alu_b;
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  function automatic logic [63:0] ref_res(input logic [63:0] a, input logic [63:0] b, input logic [1:0] fn);
    case (fn)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: return a & b;
      default: return a ^ b;
    endcase
  endfunction

  // Signed overflow from operand/result sign rules.
  function automatic logic ref_of(input logic [63:0] a, input logic [63:0] b, input logic [1:0] fn);
    logic [63:0] r;
    r = ref_res(a, b, fn);
    if (fn == 2'd0) return (a[63] == b[63]) && (r[63] != a[63]);
    if (fn == 2'd1) return (a[63] != b[63]) && (r[63] != a[63]);
    return 1'b0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_init = 1'b0;
  bit          m_pend = 1'b0;
  int          m_acc_cyc;
  logic        m_id, m_scc, m_last;
  logic [63:0] m_a, m_b, r;
  logic [1:0]  m_fn;
  logic        e_valid, e_id;
  logic [63:0] e_res, e_alu_a, e_alu_b;
  logic [1:0]  e_alu_fn;
  logic [2:0]  e_cc;
  int          cyc = 0;
  int          g_exp = 0;   // 0 none, 1 req0, 2 req1 (accept at the coming edge)
  int          acc_cycs[$];
  logic        rsp_ids[$];

  // Per-cycle compare and model advance.
  always @(negedge clk) begin
    cyc++;
    if (m_init) begin
      chk("rsp_valid", 64'(rsp_valid), 64'(e_valid));
      chk("rsp_id", 64'(rsp_id), 64'(e_id));
      chk("rsp_result", rsp_result, e_res);
      chk("cc", 64'({cc_zf, cc_sf, cc_of}), 64'(e_cc));
      chk("alu_a", alu_a, e_alu_a);
      chk("alu_b", alu_b, e_alu_b);
      chk("alu_fn", 64'(alu_fn), 64'(e_alu_fn));
    end
    g_exp = 0;
    if (!rst && m_init && !m_pend) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      if (req0_valid) g_exp = 1;
      else if (req1_valid) g_exp = 2;
`else
      if (req0_valid && req1_valid) g_exp = m_last ? 1 : 2;
      else if (req0_valid) g_exp = 1;
      else if (req1_valid) g_exp = 2;
`endif
    end
    if (m_init || rst) begin
      chk("req0_ready", 64'(req0_ready), 64'(g_exp == 1));
      chk("req1_ready", 64'(req1_ready), 64'(g_exp == 2));
    end
    if ((req0_ready && req0_valid) || (req1_ready && req1_valid)) acc_cycs.push_back(cyc);
    if (rsp_valid && rsp_ready) rsp_ids.push_back(rsp_id);

    if (rst) begin
      m_init = 1'b1; m_pend = 1'b0; e_valid = 1'b0; e_id = 1'b0; e_res = '0;
      e_cc = 3'b100; e_alu_a = '0; e_alu_b = '0; e_alu_fn = '0; m_last = 1'b1;
    end else if (m_init) begin
      if (m_pend && cyc == m_acc_cyc + 1) begin
        r = ref_res(m_a, m_b, m_fn);
        e_res = r; e_id = m_id; e_valid = 1'b1;
        if (m_scc) e_cc = {r == 64'd0, r[63], ref_of(m_a, m_b, m_fn)};
      end else if (m_pend && cyc >= m_acc_cyc + 2) begin
        if (rsp_ready) begin e_valid = 1'b0; m_pend = 1'b0; end
      end else if (g_exp != 0) begin
        m_pend = 1'b1; m_acc_cyc = cyc; m_id = (g_exp == 2);
        m_a  = m_id ? req1_a  : req0_a;
        m_b  = m_id ? req1_b  : req0_b;
        m_fn = m_id ? req1_fn : req0_fn;
        m_scc = !m_id && req0_set_cc;
        e_alu_a = m_a; e_alu_b = m_b; e_alu_fn = m_fn; m_last = m_id;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [63:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 64'h0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h7FFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'($urandom_range(0, 15));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic rnd_op(input int id);
    if (id == 0) begin
      req0_a = rnd_val(); req0_b = rnd_val(); req0_fn = 2'($urandom_range(0, 3));
      req0_set_cc = 1'($urandom_range(0, 1));
    end else begin
      req1_a = rnd_val(); req1_b = rnd_val(); req1_fn = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic drive(input int id, input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] fn, input logic scc);
    if (id == 0) begin
      req0_a = a; req0_b = b; req0_fn = fn; req0_set_cc = scc; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_fn = fn; req1_valid = 1'b1;
    end
  endtask

  // Wait (bounded) for the model to see an accept of requester id at the last edge.
  task automatic wait_accept(input int id, input string nm);
    bit got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(posedge clk); #1;
      if (g_exp == id + 1) got = 1'b1;
    end
    chk(nm, 64'(got), 64'd1);
  endtask

  // One op with literal expectations for result, owner, CC and latency.
  task automatic do_op(input int id, input logic [63:0] a, input logic [63:0] b, input logic [1:0] fn,
                       input logic scc, input logic [63:0] x_res, input logic [2:0] x_cc, input string nm);
    int  n;
    bit  got;
    @(posedge clk); #1;
    drive(id, a, b, fn, scc);
    wait_accept(id, {nm, "_accept"});
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    n = 0; got = 1'b0;
    while (n < 10 && !got) begin
      @(negedge clk); n++;
      if (rsp_valid) got = 1'b1;
    end
    chk({nm, "_latency"}, 64'(n), 64'd2);
    chk({nm, "_result"}, rsp_result, x_res);
    chk({nm, "_id"}, 64'(rsp_id), 64'(id));
    chk({nm, "_cc"}, 64'({cc_zf, cc_sf, cc_of}), 64'(x_cc));
  endtask

  int n0, n1;
  bit got;

  initial begin
    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_fn = '0; req0_set_cc = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_fn = '0;

    // 1: reset values
    @(posedge clk);
    @(negedge clk);
    chk("t1_cc", 64'({cc_zf, cc_sf, cc_of}), 64'd4);
    chk("t1_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t1_readys", 64'({req0_ready, req1_ready}), 64'd0);
    chk("t1_alu_a", alu_a, 64'd0);
    @(posedge clk); #1; rst = 1'b0;

    // 2-4: directed ops with hand-computed results
    do_op(0, 64'h0000_0000_0000_000F, 64'hFFFF_FFFF_FFFF_FFFC, 2'd1, 1'b1, 64'h13, 3'b000, "t2_sub");
    do_op(0, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 2'd1, 1'b1, 64'h0, 3'b100, "t3_sub0");
    do_op(1, 64'd5, 64'd7, 2'd0, 1'b1, 64'd12, 3'b100, "t3_req1_add");
    do_op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'd0, 1'b1, 64'h8000_0000_0000_0000, 3'b011, "t4_add_ovf");
    do_op(0, 64'hAA, 64'hAA, 2'd3, 1'b1, 64'h0, 3'b100, "t4_xor");

    // 5: both requesters streaming 6 ops each after a fresh reset
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    acc_cycs.delete(); rsp_ids.delete();
    n0 = 0; n1 = 0;
    rnd_op(0); rnd_op(1); req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 100 && (n0 < 6 || n1 < 6); k++) begin
      @(posedge clk); #1;
      if (g_exp == 1) begin n0++; if (n0 < 6) rnd_op(0); else req0_valid = 1'b0; end
      if (g_exp == 2) begin n1++; if (n1 < 6) rnd_op(1); else req1_valid = 1'b0; end
    end
    for (int k = 0; k < 20 && rsp_ids.size() < 12; k++) @(negedge clk);
    chk("t5_rsp_count", 64'(rsp_ids.size()), 64'd12);
    for (int k = 0; k < 12 && k < rsp_ids.size(); k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      chk("t5_rsp_id_order", 64'(rsp_ids[k]), 64'(k >= 6));
`else
      chk("t5_rsp_id_order", 64'(rsp_ids[k]), 64'(k % 2));
`endif
    end
    for (int k = 1; k < acc_cycs.size(); k++)
      chk("t5_accept_spacing", 64'(acc_cycs[k] - acc_cycs[k-1]), 64'd3);

    // 6: response back-pressure, then reset in EXEC
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    drive(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'd0, 1'b1);
    wait_accept(0, "t6_accept");
    req0_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin @(negedge clk); if (rsp_valid) got = 1'b1; end
    chk("t6_rsp_seen", 64'(got), 64'd1);
    @(posedge clk); #1;
    drive(1, 64'd2, 64'd3, 2'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t6_hold_valid", 64'(rsp_valid), 64'd1);
      chk("t6_hold_result", rsp_result, 64'h8000_0000_0000_0000);
      chk("t6_hold_noready", 64'({req0_ready, req1_ready}), 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_accept(1, "t6_req1_accept");
    req1_valid = 1'b0; rst = 1'b1;        // now in EXEC
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t6_rst_cc", 64'({cc_zf, cc_sf, cc_of}), 64'd4);
    do_op(0, 64'd9, 64'd4, 2'd1, 1'b1, 64'd5, 3'b000, "t6_after_rst");

    // Random traffic with back-pressure, withdrawals and occasional reset
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      if (g_exp == 1 || !req0_valid) begin
        if ($urandom_range(0, 1) == 1) begin rnd_op(0); req0_valid = 1'b1; end
        else req0_valid = 1'b0;
      end else if ($urandom_range(0, 15) == 0) req0_valid = 1'b0;
      if (g_exp == 2 || !req1_valid) begin
        if ($urandom_range(0, 1) == 1) begin rnd_op(1); req1_valid = 1'b1; end
        else req1_valid = 1'b0;
      end else if ($urandom_range(0, 15) == 0) req1_valid = 1'b0;
    end
    @(posedge clk); #1;
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
